// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks an 8-bit register mask low-to-high, one register/memory transfer per cycle.
// Optional base-register writeback in the done cycle is enabled by defining LMSM_BASE_WB_EN.
module lmsm_sequencer #(
    parameter int NREG = 8,
    parameter int AW   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [NREG-1:0]          mask,
    input  logic [AW-1:0]            base_addr,
    input  logic                     hold,
    input  logic                     flush,
    output logic                     busy,
    output logic                     xfer_valid,
    output logic [$clog2(NREG)-1:0]  reg_idx,
    output logic [AW-1:0]            mem_addr,
    output logic                     reg_we,
    output logic                     mem_we,
    output logic                     vbit,
    output logic                     stall_req,
    output logic                     done,
    output logic                     wb_valid,
    output logic [AW-1:0]            wb_addr
);
    localparam int IW = $clog2(NREG);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t          state;
    logic [NREG-1:0] rem_mask;
    logic [3:0]      cnt;
    logic            st_q;
    logic [AW-1:0]   base;

    logic [NREG-1:0] low_bit;
    logic [IW-1:0]   low_idx;
    logic            more;
    logic            in_xfer;
    logic [AW-1:0]   addr_sum;

    // Lowest set bit of the remaining mask, as one-hot and as an index.
    always_comb begin
        low_bit = rem_mask & (~rem_mask + NREG'(1));
        low_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (rem_mask[i]) low_idx = IW'(i);
        end
    end

    assign more     = (rem_mask & ~low_bit) != '0;
    assign in_xfer  = (state == S_XFER);
    assign addr_sum = base + AW'(cnt);

    assign busy       = (state != S_IDLE);
    assign xfer_valid = in_xfer;
    assign reg_idx    = in_xfer ? low_idx : '0;
    assign mem_addr   = in_xfer ? addr_sum : '0;
    assign vbit       = in_xfer & more;
    assign reg_we     = in_xfer & ~st_q & ~hold;
    assign mem_we     = in_xfer & st_q & ~hold;
    assign done       = (state == S_DONE) & ~flush;
    assign stall_req  = busy & ~done;

`ifdef LMSM_BASE_WB_EN
    // cnt equals popcount(mask) by the done cycle, so base + cnt is the updated base.
    assign wb_valid = done;
    assign wb_addr  = done ? addr_sum : '0;
`else
    assign wb_valid = 1'b0;
    assign wb_addr  = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            rem_mask <= '0;
            cnt      <= '0;
            st_q     <= 1'b0;
            base     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        rem_mask <= mask;
                        base     <= base_addr;
                        st_q     <= is_store;
                        cnt      <= '0;
                        state    <= (mask != '0) ? S_XFER : S_DONE;
                    end
                end
                S_XFER: begin
                    if (flush) begin
                        state    <= S_IDLE;
                        rem_mask <= '0;
                    end else if (!hold) begin
                        rem_mask <= rem_mask & ~low_bit;
                        cnt      <= cnt + 4'd1;
                        if (!more) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    rem_mask <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Multi-cycle sequencer for the load-multiple (LM) and store-multiple (SM) instructions of the pipelined RISC core. It accepts an 8-bit register mask and a base address, then walks the set bits from lowest to highest index, emitting one register/memory transfer per cycle. Its per-transfer `vbit` and `stall_req` outputs drive the hazard unit's LM/SM stall and priority-encoder-enable logic, and its address output feeds the memory stage.

## Interface
- `NREG`, default 8: register-file size and mask width. Fixed at 8 for this core; index width is 3.
- `AW`, default 16: memory address width.
---
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `start`  in  1  request to begin an LM/SM sequence, sampled at a clock edge.
- `is_store`  in  1  latched with `start`: 1 for SM, 0 for LM.
- `mask`  in  NREG  register mask, latched with `start`.
- `base_addr`  in  AW  first memory address, latched with `start`.
- `hold`  in  1  downstream stall; freezes the sequencer state.
- `flush`  in  1  aborts the sequence in progress.
- `busy`  out  1  high in XFER and DONE.
- `xfer_valid`  out  1  the current transfer is valid.
- `reg_idx`  out  3  register for the current transfer.
- `mem_addr`  out  AW  memory address for the current transfer.
- `reg_we`  out  1  `xfer_valid & ~is_store & ~hold`.
- `mem_we`  out  1  `xfer_valid & is_store & ~hold`.
- `vbit`  out  1  more transfers remain after the current one.
- `stall_req`  out  1  `busy & ~done`; the hazard unit freezes PC/FD/DR/RE while this is high.
- `done`  out  1  one-cycle completion pulse.
- `wb_valid`, `wb_addr`  out  1 / AW  base-writeback outputs (see Configuration).

## Operation
- FSM states: IDLE, XFER, DONE. State register, `rem_mask` (NREG), `cnt` (4 bits), and the latched `is_store` and `base`.
- IDLE:
  - On `start`, latch `mask`, `base_addr` and `is_store`, and clear `cnt`.
  - If `mask != 0`, go to XFER; if `mask == 0`, go to DONE (no transfers).
  - `start` is ignored in every state other than IDLE.
- XFER outputs (combinational from state):
  - `reg_idx` = index of the lowest set bit of `rem_mask`.
  - `mem_addr` = `base + cnt`, truncated modulo 2^AW, so the address wraps.
  - `vbit` = `(rem_mask & ~onehot(reg_idx)) != 0`.
  - `xfer_valid` = 1.
- XFER edge with `hold` = 0: clear the lowest set bit of `rem_mask` and increment `cnt`. If `vbit` = 0, go to DONE.
- XFER edge with `hold` = 1: all state holds; outputs remain stable and the transfer is repeated.
- DONE: `done` = 1 for one cycle, then IDLE. `hold` does not stall DONE.
- `flush` has priority over `hold` and `start`:
  - In XFER or DONE, `flush` sends the FSM to IDLE at the next edge, clears `rem_mask`, and suppresses `done`.
  - `flush` in IDLE with `start` also set: `start` is discarded.
- `reset` at any time: all state clears immediately to IDLE.
- Output reset values are all 0: `busy`, `xfer_valid`, `reg_idx`, `mem_addr`, `reg_we`, `mem_we`, `vbit`, `stall_req`, `done`, `wb_valid`, `wb_addr`.
- Outside XFER, `reg_idx`, `mem_addr` and `vbit` drive 0.

## Timing
- A `start` sampled at edge N produces the first `xfer_valid` in cycle N+1.
- Without holds, there is one transfer per cycle. Transfers occupy popcount(`mask`) cycles, then `done` follows in the next cycle.
- Total `busy` cycles = popcount(`mask`) + 1. With `mask == 0`, `busy` is high for 1 cycle.
- Each `hold` cycle in XFER adds exactly one cycle.
- The earliest accepted back-to-back `start` is in the `done` cycle + 1, i.e. the first IDLE cycle.

## Configuration
- `LMSM_BASE_WB_EN` defined:
  - In the `done` cycle, `wb_valid` = `~flush` and `wb_addr` = `base + popcount(mask)`, modulo 2^AW.
  - Used for an auto-incremented base register.
- `LMSM_BASE_WB_EN` undefined: `wb_valid` and `wb_addr` are tied to 0 and the adder is absent.

## Test plan
- LM case: `start` with `mask` = 0xA5, `base_addr` = 0x0100, `is_store` = 0.
  - Cycles 1-4 give `reg_idx` 0, 2, 5, 7 with `mem_addr` 0x0100-0x0103.
  - `vbit` reads 1, 1, 1, 0, and `reg_we` is high on each cycle.
  - `done` pulses in cycle 5, and `busy` is high for 5 cycles.
- Empty mask: `mask` = 0x00 gives no `xfer_valid` and `done` in cycle 1. With the macro, `wb_addr` = `base_addr`.
- Hold and wrap: `is_store` = 1, `mask` = 0x0F, `base_addr` = 0xFFFE, with `hold` high for 2 cycles on the second transfer.
  - Addresses are 0xFFFE, 0xFFFF (held 3 cycles), 0x0000, 0x0001.
  - `mem_we` is low during the hold; `done` arrives in cycle 7.
  - With the macro, `wb_addr` = 0x0002.
- Flush: `mask` = 0xFF with `flush` asserted during the third transfer. The FSM is IDLE next cycle, no `done` pulse occurs, and `busy` = 0.
- Start while busy: a second `start` (`mask` = 0x01) during XFER is ignored, and only the first sequence's transfers appear.
- Reset mid-sequence: asserting `reset` asynchronously between edges clears every output to 0 immediately. A new `start` after deassertion runs normally.
